// File: rtl/keypad_entry.sv
// keypad_entry: decodes the 3x4 keypad cell under the cursor on each select
// press, accumulates digit keys into a decimal amount, and hands the finished
// amount downstream over a valid/ready handshake when Enter is pressed.
module keypad_entry #(
  parameter int unsigned MAX_DIGITS = 6,
  parameter int unsigned VAL_W      = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_sel,
  input  logic [2:0]       cursor_x,
  input  logic [3:0]       cursor_y,
  output logic [VAL_W-1:0] value,
  output logic [3:0]       digit_cnt,
  output logic             entry_valid,
  input  logic             entry_ready,
  output logic             overflow_err,
  output logic [3:0]       key_code
);

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] KEY_CLR  = 4'd10;
  localparam logic [3:0] KEY_ENT  = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [VAL_W-1:0]   value_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               valid_d;
  logic               ovf_d;
  logic [3:0]         key_d;

  logic               key_hit_c;
  logic [3:0]         key_c;
  logic               is_digit_c;
  logic [VAL_W-1:0]   value_x10_c;

  // Map the cursor cell to a key code; out-of-range cells produce no hit
  always_comb begin
    key_hit_c = 1'b0;
    key_c     = KEY_NONE;
    if (btn_sel && (cursor_x <= 3'd2) && (cursor_y <= 4'd3)) begin
      key_hit_c = 1'b1;
      if (cursor_y == 4'd3) begin
        case (cursor_x)
          3'd0:    key_c = KEY_CLR;
          3'd1:    key_c = 4'd0;
          default: key_c = KEY_ENT;
        endcase
      end else begin
        key_c = (cursor_y * 4'd3) + 4'(cursor_x) + 4'd1;
      end
    end
  end

  assign is_digit_c = key_hit_c && (key_c <= 4'd9);

  // value*10 as shift-and-add, kept at VAL_W bits (cannot overflow for <= MAX_DIGITS)
  assign value_x10_c = (value << 3) + (value << 1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    value_d = value;
    cnt_d   = digit_cnt;
    ovf_d   = 1'b0;
    key_d   = key_code;

    // Every decoded press updates key_code regardless of state
    if (key_hit_c) begin
      key_d = key_c;
    end

    case (state)
      ST_ENTRY: begin
        if (is_digit_c) begin
          if ((digit_cnt == '0) && (key_c == 4'd0)) begin
            // leading zero contributes nothing
          end else if (digit_cnt < CNT_MAX) begin
            value_d = value_x10_c + VAL_W'(key_c);
            cnt_d   = digit_cnt + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (key_hit_c && (key_c == KEY_CLR)) begin
          value_d = '0;
          cnt_d   = '0;
        end else if (key_hit_c && (key_c == KEY_ENT)) begin
          if (digit_cnt != '0) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Amount frozen until downstream takes it; presses in this cycle are dropped
        if (entry_valid && entry_ready) begin
          state_d = ST_ENTRY;
          value_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ENTRY;
      end
    endcase

    valid_d = (state_d == ST_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ENTRY;
      value        <= '0;
      digit_cnt    <= '0;
      entry_valid  <= 1'b0;
      overflow_err <= 1'b0;
      key_code     <= KEY_NONE;
    end else begin
      state        <= state_d;
      value        <= value_d;
      digit_cnt    <= cnt_d;
      entry_valid  <= valid_d;
      overflow_err <= ovf_d;
      key_code     <= key_d;
    end
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Consumes the cursor position (cursor_x, cursor_y) from the cursor controller plus a select pulse, and decodes the 3x4 keypad cell under the cursor into a key. Accumulates digit keys into a decimal amount and handles Clear and Enter. On Enter it presents the amount to the downstream transaction logic over a valid/ready handshake.

Parameters:
MAX_DIGITS, 6, maximum digits accepted per entry
VAL_W, 20, width of the accumulated value; must hold 10^MAX_DIGITS-1 (999999 < 2^20)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_sel  in  1  select pulse, one cycle per press (debounced upstream)
cursor_x  in  3  cursor column, valid 0..2
cursor_y  in  4  cursor row, valid 0..3
value  out  VAL_W  current accumulated amount; held stable while entry_valid=1
digit_cnt  out  4  number of digits accepted in the current entry
entry_valid  out  1  completed entry available on value
entry_ready  in  1  downstream accepts entry
overflow_err  out  1  one-cycle pulse when a digit is rejected because the entry is full
key_code  out  4  last decoded key: 0-9 digit, 10 CLR, 11 ENT, 15 none

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: value=0, digit_cnt=0, entry_valid=0, overflow_err=0, key_code=15, state=ENTRY.
- Key map: cursor is sampled in the same cycle as btn_sel.
  - Rows 0..2: digit = cursor_y*3 + cursor_x + 1, giving 1..9.
  - Row 3: x=0 is CLR, x=1 is digit 0, x=2 is ENT.
- Out-of-range cursor (x>2 or y>3) with btn_sel: press ignored, no state change, key_code unchanged.
- key_code updates on every decoded press in any state, one cycle after btn_sel.
- State machine, two states: ENTRY and HOLD.
- ENTRY, digit d:
  - If digit_cnt==0 and d==0: leading zero, ignored; value and digit_cnt unchanged.
  - Else if digit_cnt < MAX_DIGITS: value <= value*10 + d and digit_cnt <= digit_cnt+1. Arithmetic is unsigned, VAL_W wide, and cannot overflow by construction.
  - Else (digit_cnt == MAX_DIGITS): value unchanged; overflow_err high for exactly the next cycle.
- ENTRY, CLR: value <= 0, digit_cnt <= 0.
- ENTRY, ENT:
  - If digit_cnt==0: ignored.
  - Else: go to HOLD; entry_valid=1 from the next cycle.
- HOLD:
  - All presses are ignored except the key_code update; value and digit_cnt are frozen.
  - entry_valid stays high until entry_valid && entry_ready at a clock edge.
  - On that edge: go to ENTRY, entry_valid=0, value=0, digit_cnt=0.
- Latency: btn_sel to value/digit_cnt/entry_valid update is 1 cycle. The first ready edge after entry_valid rises completes the transfer.
- entry_ready is ignored in ENTRY.
- btn_sel arriving in the same cycle as the accepting handshake is dropped.
- Reset mid-operation: asserting rst_n low in any state returns all outputs to their reset values immediately (asynchronous). A pending entry is discarded.

Test Plan:
- Reset, then select (0,0),(1,0),(2,0) -> value=1,12,123 one cycle after each press; digit_cnt=3; key_code=1,2,3.
- Entry 123, select (2,3) ENT, entry_ready=0 for 3 cycles then 1 -> entry_valid=1 with value=123 stable for 4 cycles; on the ready edge entry_valid=0, value=0, digit_cnt=0.
- Enter 9 seven times, i.e. (2,2) x7 -> value=999999, digit_cnt=6; on the 7th press overflow_err=1 for one cycle and value stays 999999.
- Select (1,3) twice, then (0,0), then (1,3) -> leading zeros ignored; final value=10, digit_cnt=2. Then (0,3) CLR -> value=0, digit_cnt=0.
- ENT with digit_cnt=0 -> entry_valid stays 0. Cursor (3,0) or (0,4) with btn_sel -> no change to any output.
- In HOLD with value=45, press digit 7 -> value stays 45 and key_code=7. Then assert rst_n=0 mid-HOLD -> entry_valid=0, value=0, key_code=15 immediately.
